// File: rtl/sccb_target.sv
// SCCB/I2C register target: oversampled scl/sda, address match, 16-bit register pointer,
// write strobes per data byte and auto-incrementing reads.
module sccb_target #(
    parameter logic [6:0]  DEV_ADDR    = 7'h3C,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        meg25,
    input  logic        rst_n,
    input  logic        scl,
    inout  wire         sda,
    output logic [15:0] reg_addr,
    output logic [7:0]  wr_data,
    output logic        wr_stb,
    output logic        rd_req,
    input  logic [7:0]  rd_data,
    output logic        busy
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG_HI, REG_HI_ACK, REG_LO, REG_LO_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   sda_oe;
    logic [7:0]             shreg;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   rd_mode;
    logic                   wr_first;

    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;
    logic [7:0]             byte_in;

    // Open-drain pad: only ever pulls low
    assign sda = sda_oe ? 1'b0 : 1'bz;

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign byte_in   = {shreg[6:0], sda_s};

    // Synchronisers reset to the idle-bus level so reset never fakes an edge
    always_ff @(posedge meg25 or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    always_ff @(posedge meg25 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            reg_addr <= '0;
            wr_data  <= '0;
            wr_stb   <= 1'b0;
            rd_req   <= 1'b0;
            busy     <= 1'b0;
            sda_oe   <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            rd_mode  <= 1'b0;
            wr_first <= 1'b0;
        end else begin
            wr_stb <= 1'b0;
            rd_req <= 1'b0;
            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state   <= IDLE;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise && bit_cnt < CNT_W'(8)) begin
                            shreg   <= byte_in;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            // Early read request gives rd_data time before the ACK-slot fall
                            if (bit_cnt == CNT_W'(7) && byte_in[7:1] == DEV_ADDR && byte_in[0])
                                rd_req <= 1'b1;
                        end else if (scl_fall && bit_cnt == CNT_W'(8)) begin
                            if (shreg[7:1] == DEV_ADDR) begin
                                sda_oe  <= 1'b1;
                                busy    <= 1'b1;
                                rd_mode <= shreg[0];
                                state   <= ADDR_ACK;
                            end else begin
                                busy  <= 1'b0;
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= '0;
                            if (rd_mode) begin
                                shreg  <= rd_data;
                                sda_oe <= ~rd_data[7];
                                state  <= RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= REG_HI;
                            end
                        end
                    end
                    REG_HI, REG_LO, WDATA: begin
                        if (scl_rise && bit_cnt < CNT_W'(8)) begin
                            shreg   <= byte_in;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            if (state == WDATA && bit_cnt == CNT_W'(7)) begin
                                wr_data  <= byte_in;
                                wr_stb   <= 1'b1;
                                wr_first <= 1'b0;
                                if (!wr_first)
                                    reg_addr <= reg_addr + 16'd1;
                            end
                        end else if (scl_fall && bit_cnt == CNT_W'(8)) begin
                            sda_oe <= 1'b1;
                            case (state)
                                REG_HI: begin
                                    reg_addr[15:8] <= shreg;
                                    state          <= REG_HI_ACK;
                                end
                                REG_LO: begin
                                    reg_addr[7:0] <= shreg;
                                    state         <= REG_LO_ACK;
                                end
                                default: state <= WDATA_ACK;
                            endcase
                        end
                    end
                    REG_HI_ACK, REG_LO_ACK, WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            if (state == REG_HI_ACK) begin
                                state <= REG_LO;
                            end else begin
                                if (state == REG_LO_ACK)
                                    wr_first <= 1'b1;
                                state <= WDATA;
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_rise && bit_cnt < CNT_W'(8)) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end else if (scl_fall) begin
                            if (bit_cnt == CNT_W'(8)) begin
                                sda_oe <= 1'b0;
                                state  <= RDATA_ACK;
                            end else begin
                                shreg  <= {shreg[6:0], 1'b0};
                                sda_oe <= ~shreg[6];
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            if (sda_s) begin
                                state <= WAIT_STOP;
                            end else begin
                                reg_addr <= reg_addr + 16'd1;
                                rd_req   <= 1'b1;
                                bit_cnt  <= CNT_W'(9);
                            end
                        end else if (scl_fall && bit_cnt == CNT_W'(9)) begin
                            shreg   <= rd_data;
                            sda_oe  <= ~rd_data[7];
                            bit_cnt <= '0;
                            state   <= RDATA;
                        end
                    end
                    WAIT_STOP: sda_oe <= 1'b0;
                    default:   sda_oe <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_target.sv
// Bus-level bench for sccb_target: a bit-banged SCCB master drives directed and random
// transfers; a monitor checks every wr_stb / rd_req against a queue of expected events.
module tb_sccb_target;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        meg25 = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl   = 1'b1;
    logic        m_low = 1'b0;
    wire         sda;
    logic [15:0] reg_addr;
    logic [7:0]  wr_data;
    logic        wr_stb;
    logic        rd_req;
    logic [7:0]  rd_data = 8'h00;
    logic        busy;

    int tests = 0;
    int fails = 0;

    wr_t         wr_q[$];
    logic [15:0] rd_q[$];
    wr_t         mon_w;
    logic [15:0] mon_r;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #20 meg25 = ~meg25;

    sccb_target #(.DEV_ADDR(7'h3C), .SYNC_STAGES(2)) dut (
        .meg25    (meg25),
        .rst_n    (rst_n),
        .scl      (scl),
        .sda      (sda),
        .reg_addr (reg_addr),
        .wr_data  (wr_data),
        .wr_stb   (wr_stb),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .busy     (busy)
    );

    // Target register contents as seen by reads
    function automatic logic [7:0] mem_val(input logic [15:0] a);
        if (a == 16'h300A) return 8'h56;
        return 8'(a[7:0] ^ a[15:8] ^ 8'hA5);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe/request must match the next expected event
    always @(negedge meg25) begin
        if (rst_n && wr_stb === 1'b1) begin
            if (wr_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wr_unexpected: got addr %h data %h, expected no strobe", reg_addr, wr_data);
            end else begin
                mon_w = wr_q.pop_front();
                check("wr_addr", 32'(reg_addr), 32'(mon_w.a));
                check("wr_data", 32'(wr_data), 32'(mon_w.d));
            end
        end
        if (rst_n && rd_req === 1'b1) begin
            if (rd_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_unexpected: got rd_req at %h, expected none", reg_addr);
            end else begin
                mon_r = rd_q.pop_front();
                check("rd_addr", 32'(reg_addr), 32'(mon_r));
                rd_data = mem_val(mon_r);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge meg25);
    endtask

    task automatic bus_start();
        m_low = 1'b0; scl = 1'b1; wait_cyc(8);
        m_low = 1'b1; wait_cyc(8);
        scl = 1'b0; wait_cyc(4);
    endtask

    task automatic bus_rstart();
        m_low = 1'b0; wait_cyc(4);
        scl = 1'b1; wait_cyc(8);
        m_low = 1'b1; wait_cyc(8);
        scl = 1'b0; wait_cyc(4);
    endtask

    task automatic bus_stop();
        m_low = 1'b1; wait_cyc(4);
        scl = 1'b1; wait_cyc(8);
        m_low = 1'b0; wait_cyc(8);
    endtask

    // One scl period: present b while low, sample the bus mid-high
    task automatic clk_bit(input logic b, output logic s);
        m_low = ~b; wait_cyc(4);
        scl = 1'b1; wait_cyc(4);
        s = (sda === 1'b0) ? 1'b0 : 1'b1;
        wait_cyc(4);
        scl = 1'b0; wait_cyc(4);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        acked = ~s;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(~master_ack, s);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_reg_addr"}, 32'(reg_addr), 32'h0);
        check({tag, "_wr_data"}, 32'(wr_data), 32'h0);
        check({tag, "_wr_stb"}, 32'(wr_stb), 32'h0);
        check({tag, "_rd_req"}, 32'(rd_req), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_sda"}, 32'(sda), 32'h1);
    endtask

    initial begin
        logic        ack;
        logic        s;
        logic [7:0]  d;
        logic [15:0] a;
        logic [15:0] ptr;
        logic [6:0]  dev;
        int          n;
        int          kind;

        wait_cyc(4);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_cyc(4);

        // Single register write
        wr_q.push_back('{a: 16'h3008, d: 8'h82});
        bus_start();
        write_byte(8'h78, ack); check("t1_ack_dev", 32'(ack), 32'h1);
        check("t1_busy", 32'(busy), 32'h1);
        write_byte(8'h30, ack); check("t1_ack_hi", 32'(ack), 32'h1);
        write_byte(8'h08, ack); check("t1_ack_lo", 32'(ack), 32'h1);
        write_byte(8'h82, ack); check("t1_ack_data", 32'(ack), 32'h1);
        bus_stop();
        check("t1_busy_after", 32'(busy), 32'h0);
        check("t1_reg_addr", 32'(reg_addr), 32'h3008);
        check("t1_wr_data", 32'(wr_data), 32'h82);
        check("t1_pending", 32'(wr_q.size()), 32'h0);

        // Wrong device address: ignored to STOP
        bus_start();
        write_byte(8'h7A, ack); check("t2_nack", 32'(ack), 32'h0);
        check("t2_busy", 32'(busy), 32'h0);
        write_byte(8'h30, ack); check("t2_nack_more", 32'(ack), 32'h0);
        write_byte(8'h55, ack);
        bus_stop();
        check("t2_reg_addr", 32'(reg_addr), 32'h3008);

        // Bursts with pointer increment and wrap
        wr_q.push_back('{a: 16'h1234, d: 8'hAA});
        wr_q.push_back('{a: 16'h1235, d: 8'hBB});
        wr_q.push_back('{a: 16'h1236, d: 8'hCC});
        bus_start();
        write_byte(8'h78, ack); write_byte(8'h12, ack); write_byte(8'h34, ack);
        write_byte(8'hAA, ack); write_byte(8'hBB, ack); write_byte(8'hCC, ack);
        check("t3_ack_last", 32'(ack), 32'h1);
        bus_stop();
        wr_q.push_back('{a: 16'hFFFF, d: 8'h01});
        wr_q.push_back('{a: 16'h0000, d: 8'h02});
        bus_start();
        write_byte(8'h78, ack); write_byte(8'hFF, ack); write_byte(8'hFF, ack);
        write_byte(8'h01, ack); write_byte(8'h02, ack);
        bus_stop();
        check("t3_wrap_addr", 32'(reg_addr), 32'h0000);
        check("t3_pending", 32'(wr_q.size()), 32'h0);

        // Random read, single byte, master NACK
        bus_start();
        write_byte(8'h78, ack); write_byte(8'h30, ack); write_byte(8'h0A, ack);
        rd_q.push_back(16'h300A);
        bus_rstart();
        write_byte(8'h79, ack); check("t4_ack_rd", 32'(ack), 32'h1);
        read_byte(1'b0, d);
        check("t4_rd_byte", 32'(d), 32'h56);
        check("t4_released", 32'(sda), 32'h1);
        bus_stop();

        // Two-byte read: ACK then NACK
        bus_start();
        write_byte(8'h78, ack); write_byte(8'h30, ack); write_byte(8'h0A, ack);
        rd_q.push_back(16'h300A);
        rd_q.push_back(16'h300B);
        bus_rstart();
        write_byte(8'h79, ack);
        read_byte(1'b1, d); check("t5_byte0", 32'(d), 32'(mem_val(16'h300A)));
        read_byte(1'b0, d); check("t5_byte1", 32'(d), 32'(mem_val(16'h300B)));
        check("t5_released", 32'(sda), 32'h1);
        bus_stop();
        check("t5_rd_pending", 32'(rd_q.size()), 32'h0);

        // STOP mid data byte: no strobe for the partial byte
        bus_start();
        write_byte(8'h78, ack); write_byte(8'h30, ack); write_byte(8'h10, ack);
        for (int i = 0; i < 4; i++) clk_bit(i[0], s);
        bus_stop();
        check("t6_reg_addr", 32'(reg_addr), 32'h3010);
        check("t6_busy", 32'(busy), 32'h0);

        // Reset asserted while the target is driving ACK
        bus_start();
        for (int i = 7; i >= 0; i--) clk_bit(1'(8'h78 >> i), s);
        m_low = 1'b0; wait_cyc(4);
        scl = 1'b1; wait_cyc(2);
        check("t6_ack_driven", 32'(sda), 32'h0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        wait_cyc(2);
        scl = 1'b0; wait_cyc(4);
        rst_n = 1'b1; wait_cyc(4);
        bus_stop();
        check("t6_post_reg_addr", 32'(reg_addr), 32'h0);
        ptr = 16'h0000;

        // Randomised transfers against the pointer/memory model
        for (int r = 0; r < 24; r++) begin
            kind = int'($urandom_range(0, 2));
            a    = 16'($urandom);
            n    = int'($urandom_range(1, 4));
            if (kind == 0) begin
                bus_start();
                write_byte(8'h78, ack); write_byte(a[15:8], ack); write_byte(a[7:0], ack);
                for (int k = 0; k < n; k++) begin
                    d = 8'($urandom);
                    wr_q.push_back('{a: 16'(a + 16'(k)), d: d});
                    write_byte(d, ack);
                end
                check("rnd_wr_ack", 32'(ack), 32'h1);
                bus_stop();
                ptr = 16'(a + 16'(n - 1));
            end else if (kind == 1) begin
                bus_start();
                write_byte(8'h78, ack); write_byte(a[15:8], ack); write_byte(a[7:0], ack);
                for (int k = 0; k < n; k++) rd_q.push_back(16'(a + 16'(k)));
                bus_rstart();
                write_byte(8'h79, ack);
                for (int k = 0; k < n; k++) begin
                    read_byte(k < n - 1, d);
                    check("rnd_rd_byte", 32'(d), 32'(mem_val(16'(a + 16'(k)))));
                end
                bus_stop();
                ptr = 16'(a + 16'(n - 1));
            end else begin
                dev = 7'($urandom);
                if (dev == 7'h3C) dev = 7'h3D;
                bus_start();
                write_byte({dev, 1'($urandom)}, ack);
                check("rnd_bad_nack", 32'(ack), 32'h0);
                write_byte(8'($urandom), ack);
                bus_stop();
            end
            check("rnd_ptr", 32'(reg_addr), 32'(ptr));
        end

        wait_cyc(10);
        check("end_wr_pending", 32'(wr_q.size()), 32'h0);
        check("end_rd_pending", 32'(rd_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
